decode_fetch_queue: RTL and testbench
=====================================

# decode_fetch_queue

Parametrised fetch-to-decode instruction queue that sits between the fetch stage and the decode stage. It replaces the fixed single pipeline register with a DEPTH-entry first-word-fall-through buffer. The buffer carries the full fetch packet (instruction, PCs, branch-prediction metadata, trace flag) under valid/ready handshakes on both sides and supports a single-cycle flush. It decouples fetch from decode stalls and presents a canonical NOP to decode whenever it is empty.

## Interface
Parameters:
- ADDR_WIDTH, 64, PC / target address width
- INSTR_WIDTH, 32, instruction width
- DEPTH, 4, number of entries; power of two, ≥ 2
- WAY_W, 2, BTB way index width
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_arst  input  1  asynchronous active-low reset (0 = reset)
- i_valid  input  1  fetch packet valid
- o_ready  output  1  queue can accept a packet
- i_instruction  input  INSTR_WIDTH  fetched instruction
- i_pc / i_pc_plus4  input  ADDR_WIDTH  PC and PC+4
- i_pc_target_addr_pred  input  ADDR_WIDTH  predicted target
- i_btb_way  input  WAY_W  BTB way hit
- i_branch_pred_taken  input  1  prediction taken
- i_log_trace  input  1  trace-log enable
- i_flush  input  1  discard all entries (branch mispredict / trap)
- o_valid  output  1  head packet valid for decode
- i_ready  input  1  decode accepts head packet
- o_instruction, o_pc, o_pc_plus4, o_pc_target_addr_pred, o_btb_way, o_branch_pred_taken, o_log_trace  output  as inputs  head packet
- o_count  output  CNT_W  current occupancy
- o_empty / o_full  output  1  count == 0 / count == DEPTH

## Operation
- push = i_valid & o_ready & ~i_flush; pop = o_valid & i_ready & ~i_flush.
- o_ready = ~o_full. It is purely registered state and independent of i_ready, so there is no combinational path through the queue.
- o_valid = ~o_empty. Head payload is read combinationally from the entry at the read pointer (FWFT).
- When o_valid = 0, outputs are forced as follows:
  - o_instruction = NOP_INSTR (32'h0000_0013).
  - All other payload outputs = 0.
- Write pointer and read pointer are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- Occupancy update:
  - Push only: count +1.
  - Pop only: count −1.
  - Push and pop together: count unchanged, both pointers advance.
- Flush: next edge sets both pointers and count to 0. Any push or pop in the flush cycle is discarded. Flush has priority over everything.
- Storage array is not reset; only pointers and count are reset. Stale data is never visible because of the output masking.

## Timing
- Reset (i_arst = 0, asynchronous) forces: count = 0, pointers = 0, o_valid = 0, o_empty = 1, o_full = 0, o_ready = 1, o_count = 0, o_instruction = NOP_INSTR, other payload 0. Reset may assert mid-operation; contents are lost immediately.
- Latency: a packet pushed at edge t appears with o_valid = 1 in the cycle after edge t. There is no same-cycle bypass when empty.
- Empty: pop is impossible. A push in the same cycle only fills the queue.
- Full: o_ready = 0, so no push is possible. A pop in that cycle frees a slot, and o_ready rises after the edge.
- Wrap-around: ordering is preserved across a pointer wrap. Packets exit in push order.
- Flush with count = DEPTH and i_valid = 1: after the edge count = 0, o_valid = 0, o_ready = 1.

## Structure
- decode_pkg holds:
  - typedef fetch_pkt_t (packed struct: instruction, pc, pc_plus4, pc_target_addr_pred, btb_way, branch_pred_taken, log_trace).
  - Constant NOP_INSTR.
- decode_stage reuses the package so it can take the packet directly.
- Storage is an array of fetch_pkt_t inside this module. No sub-module is needed; pointer/count logic is one always_ff and output masking is one always_comb.

## Test plan
- Reset and basic flow: release reset, push pc = 0x1000 then 0x1004. o_valid rises the cycle after the first push, o_pc = 0x1000 then 0x1004 on two pops, o_count goes 1, 2, 1, 0.
- Fill and backpressure: DEPTH = 4, i_ready = 0, push 5 packets. o_full = 1 and o_ready = 0 after the 4th. The 5th is held by fetch and enters only after one pop. Output order is intact.
- Simultaneous push/pop: at count = 2, push and pop for 8 cycles across pointer wrap. Count stays 2 and the sequence is in order.
- Flush priority: count = 3, assert i_flush with i_valid = 1 and i_ready = 1. Next cycle count = 0, o_valid = 0, o_instruction = 0x00000013. The flushed-cycle packet never appears.
- Mid-operation reset: count = 2, pull i_arst low between edges. Outputs go to reset values immediately, without waiting for a clock edge.
- Metadata carry: push btb_way = 2'b10, pred_taken = 1, target = 0x2000, log_trace = 1. The same values appear on the outputs when that entry is at the head.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared fetch/decode definitions: the fetch packet layout and the canonical NOP.
// The packet uses the default core widths so decode can take it directly.
package decode_pkg;

  localparam int PKT_ADDR_W  = 64;
  localparam int PKT_INSTR_W = 32;
  localparam int PKT_WAY_W   = 2;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [PKT_INSTR_W-1:0] instruction;
    logic [PKT_ADDR_W-1:0]  pc;
    logic [PKT_ADDR_W-1:0]  pc_plus4;
    logic [PKT_ADDR_W-1:0]  pc_target_addr_pred;
    logic [PKT_WAY_W-1:0]   btb_way;
    logic                   branch_pred_taken;
    logic                   log_trace;
  } fetch_pkt_t;

endpackage

// File: rtl/decode_fetch_queue.sv
// Fetch-to-decode FWFT instruction queue. Holds DEPTH fetch packets, decouples
// fetch from decode stalls, flushes in one cycle and shows a NOP when empty.
module decode_fetch_queue
  import decode_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4,
  parameter int WAY_W       = 2,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [INSTR_WIDTH-1:0] i_instruction,
  input  logic [ADDR_WIDTH-1:0]  i_pc,
  input  logic [ADDR_WIDTH-1:0]  i_pc_plus4,
  input  logic [ADDR_WIDTH-1:0]  i_pc_target_addr_pred,
  input  logic [WAY_W-1:0]       i_btb_way,
  input  logic                   i_branch_pred_taken,
  input  logic                   i_log_trace,
  input  logic                   i_flush,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [INSTR_WIDTH-1:0] o_instruction,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [ADDR_WIDTH-1:0]  o_pc_plus4,
  output logic [ADDR_WIDTH-1:0]  o_pc_target_addr_pred,
  output logic [WAY_W-1:0]       o_btb_way,
  output logic                   o_branch_pred_taken,
  output logic                   o_log_trace,
  output logic [CNT_W-1:0]       o_count,
  output logic                   o_empty,
  output logic                   o_full
);

  localparam int PTR_W = $clog2(DEPTH);

  // Same layout as decode_pkg::fetch_pkt_t, sized by this instance's parameters.
  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instruction;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH-1:0]  pc_plus4;
    logic [ADDR_WIDTH-1:0]  pc_target_addr_pred;
    logic [WAY_W-1:0]       btb_way;
    logic                   branch_pred_taken;
    logic                   log_trace;
  } queue_pkt_t;

  queue_pkt_t             mem [DEPTH];
  queue_pkt_t             wr_pkt;
  queue_pkt_t             head_pkt;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   push;
  logic                   pop;

  assign o_empty = (count == '0);
  assign o_full  = (count == CNT_W'(DEPTH));
  assign o_ready = ~o_full;
  assign o_valid = ~o_empty;
  assign o_count = count;

  assign push = i_valid & o_ready & ~i_flush;
  assign pop  = o_valid & i_ready & ~i_flush;

  assign wr_pkt = '{
    instruction:         i_instruction,
    pc:                  i_pc,
    pc_plus4:            i_pc_plus4,
    pc_target_addr_pred: i_pc_target_addr_pred,
    btb_way:             i_btb_way,
    branch_pred_taken:   i_branch_pred_taken,
    log_trace:           i_log_trace
  };

  // Pointer and occupancy control; flush wins over any push/pop in its cycle.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Packet storage; left unreset because the output mask hides stale entries.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= wr_pkt;
  end

  // Head presentation: live entry when valid, otherwise a canonical NOP.
  always_comb begin
    head_pkt             = '0;
    head_pkt.instruction = INSTR_WIDTH'(NOP_INSTR);
    if (o_valid) head_pkt = mem[rd_ptr];
  end

  assign o_instruction         = head_pkt.instruction;
  assign o_pc                  = head_pkt.pc;
  assign o_pc_plus4            = head_pkt.pc_plus4;
  assign o_pc_target_addr_pred = head_pkt.pc_target_addr_pred;
  assign o_btb_way             = head_pkt.btb_way;
  assign o_branch_pred_taken   = head_pkt.branch_pred_taken;
  assign o_log_trace           = head_pkt.log_trace;

endmodule

// File: tb/tb_decode_fetch_queue.sv
// Bench for decode_fetch_queue: queue-based reference model compared every
// falling edge, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_decode_fetch_queue;
  import decode_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             i_arst = 1'b0;
  logic             i_valid = 1'b0;
  logic             i_ready = 1'b0;
  logic             i_flush = 1'b0;
  fetch_pkt_t       in_pkt = '0;
  logic             o_ready, o_valid, o_empty, o_full;
  logic [CNT_W-1:0] o_count;
  fetch_pkt_t       out_pkt;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  decode_fetch_queue #(.ADDR_WIDTH(64), .INSTR_WIDTH(32), .DEPTH(DEPTH), .WAY_W(2)) dut (
    .i_clk                 (clk),
    .i_arst                (i_arst),
    .i_valid               (i_valid),
    .o_ready               (o_ready),
    .i_instruction         (in_pkt.instruction),
    .i_pc                  (in_pkt.pc),
    .i_pc_plus4            (in_pkt.pc_plus4),
    .i_pc_target_addr_pred (in_pkt.pc_target_addr_pred),
    .i_btb_way             (in_pkt.btb_way),
    .i_branch_pred_taken   (in_pkt.branch_pred_taken),
    .i_log_trace           (in_pkt.log_trace),
    .i_flush               (i_flush),
    .o_valid               (o_valid),
    .i_ready               (i_ready),
    .o_instruction         (out_pkt.instruction),
    .o_pc                  (out_pkt.pc),
    .o_pc_plus4            (out_pkt.pc_plus4),
    .o_pc_target_addr_pred (out_pkt.pc_target_addr_pred),
    .o_btb_way             (out_pkt.btb_way),
    .o_branch_pred_taken   (out_pkt.branch_pred_taken),
    .o_log_trace           (out_pkt.log_trace),
    .o_count               (o_count),
    .o_empty               (o_empty),
    .o_full                (o_full)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else passes++;
  endtask

  // Reference model: ordered list of accepted packets.
  fetch_pkt_t mq[$];
  bit         m_push, m_pop;

  always @(posedge clk or negedge i_arst) begin
    if (!i_arst) begin
      mq.delete();
    end else if (i_flush) begin
      mq.delete();
    end else begin
      m_push = i_valid && (mq.size() < DEPTH);
      m_pop  = i_ready && (mq.size() > 0);
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back(in_pkt);
    end
  end

  function automatic fetch_pkt_t model_head();
    fetch_pkt_t h;
    h = '0;
    h.instruction = NOP_INSTR;
    if (mq.size() > 0) h = mq[0];
    return h;
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    fetch_pkt_t h;
    int n;
    h = model_head();
    n = mq.size();
    check("cyc_valid", 64'(o_valid), 64'(n > 0));
    check("cyc_count", 64'(o_count), 64'(n));
    check("cyc_ready", 64'(o_ready), 64'(n < DEPTH));
    check("cyc_empty", 64'(o_empty), 64'(n == 0));
    check("cyc_full",  64'(o_full),  64'(n == DEPTH));
    check("cyc_instr", 64'(out_pkt.instruction), 64'(h.instruction));
    check("cyc_pc",    out_pkt.pc, h.pc);
    check("cyc_pc4",   out_pkt.pc_plus4, h.pc_plus4);
    check("cyc_tgt",   out_pkt.pc_target_addr_pred, h.pc_target_addr_pred);
    check("cyc_way",   64'(out_pkt.btb_way), 64'(h.btb_way));
    check("cyc_taken", 64'(out_pkt.branch_pred_taken), 64'(h.branch_pred_taken));
    check("cyc_trace", 64'(out_pkt.log_trace), 64'(h.log_trace));
  end

  function automatic fetch_pkt_t mk(input logic [63:0] pc);
    fetch_pkt_t p;
    p.instruction         = {pc[15:0], 16'h00b3};
    p.pc                  = pc;
    p.pc_plus4            = pc + 64'd4;
    p.pc_target_addr_pred = pc + 64'h100;
    p.btb_way             = pc[3:2];
    p.branch_pred_taken   = pc[2];
    p.log_trace           = pc[3];
    return p;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) cyc();
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_empty", 64'(o_empty), 64'd1);
    check("rst_full",  64'(o_full),  64'd0);
    check("rst_count", 64'(o_count), 64'd0);
    check("rst_instr", 64'(out_pkt.instruction), 64'h13);
    check("rst_pc",    out_pkt.pc, 64'd0);
    i_arst = 1'b1;
    cyc();

    // Basic flow
    i_valid = 1'b1; in_pkt = mk(64'h1000);
    cyc();
    check("t1_valid", 64'(o_valid), 64'd1);
    check("t1_count1", 64'(o_count), 64'd1);
    check("t1_model1", 64'(mq.size()), 64'd1);
    in_pkt = mk(64'h1004);
    cyc();
    check("t1_count2", 64'(o_count), 64'd2);
    check("t1_pc0", out_pkt.pc, 64'h1000);
    i_valid = 1'b0; i_ready = 1'b1;
    cyc();
    check("t1_count3", 64'(o_count), 64'd1);
    check("t1_pc1", out_pkt.pc, 64'h1004);
    check("t1_model_pc1", mq[0].pc, 64'h1004);
    cyc();
    check("t1_count4", 64'(o_count), 64'd0);
    check("t1_empty", 64'(o_valid), 64'd0);
    i_ready = 1'b0;

    // Fill and backpressure
    i_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_pkt = mk(64'h2000 + 64'(4 * k));
      cyc();
    end
    check("t2_full", 64'(o_full), 64'd1);
    check("t2_ready", 64'(o_ready), 64'd0);
    in_pkt = mk(64'h2010);
    cyc();
    check("t2_held_count", 64'(o_count), 64'd4);
    i_ready = 1'b1;
    cyc();
    check("t2_pop_count", 64'(o_count), 64'd3);
    check("t2_pop_ready", 64'(o_ready), 64'd1);
    check("t2_pop_pc", out_pkt.pc, 64'h2004);
    i_ready = 1'b0;
    cyc();
    check("t2_fifth_in", 64'(o_count), 64'd4);
    i_valid = 1'b0; i_ready = 1'b1;
    repeat (3) cyc();
    check("t2_last_pc", out_pkt.pc, 64'h2010);
    check("t2_model_last", mq[0].pc, 64'h2010);
    cyc();
    i_ready = 1'b0;

    // Simultaneous push/pop across pointer wrap
    i_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_pkt = mk(64'h3000 + 64'(4 * k));
      cyc();
    end
    i_ready = 1'b1;
    for (int k = 2; k < 10; k++) begin
      in_pkt = mk(64'h3000 + 64'(4 * k));
      cyc();
      check("t3_count", 64'(o_count), 64'd2);
      check("t3_pc", out_pkt.pc, 64'h3000 + 64'(4 * (k - 1)));
    end
    i_valid = 1'b0;
    repeat (2) cyc();
    i_ready = 1'b0;

    // Flush priority at count 3
    i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_pkt = mk(64'h4000 + 64'(4 * k));
      cyc();
    end
    in_pkt = mk(64'h4ff0); i_ready = 1'b1; i_flush = 1'b1;
    cyc();
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    check("t4_count", 64'(o_count), 64'd0);
    check("t4_valid", 64'(o_valid), 64'd0);
    check("t4_instr", 64'(out_pkt.instruction), 64'h13);
    cyc();
    check("t4_still_empty", 64'(o_count), 64'd0);

    // Flush while full with fetch still valid
    i_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_pkt = mk(64'h5000 + 64'(4 * k));
      cyc();
    end
    check("t4b_full", 64'(o_full), 64'd1);
    i_flush = 1'b1;
    cyc();
    i_flush = 1'b0; i_valid = 1'b0;
    check("t4b_count", 64'(o_count), 64'd0);
    check("t4b_ready", 64'(o_ready), 64'd1);
    check("t4b_valid", 64'(o_valid), 64'd0);

    // Mid-operation asynchronous reset
    i_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_pkt = mk(64'h6000 + 64'(4 * k));
      cyc();
    end
    i_valid = 1'b0;
    check("t5_pre_count", 64'(o_count), 64'd2);
    #1 i_arst = 1'b0;
    #1;
    check("t5_valid", 64'(o_valid), 64'd0);
    check("t5_count", 64'(o_count), 64'd0);
    check("t5_ready", 64'(o_ready), 64'd1);
    check("t5_instr", 64'(out_pkt.instruction), 64'h13);
    check("t5_pc", out_pkt.pc, 64'd0);
    cyc();
    i_arst = 1'b1;
    cyc();

    // Metadata carry
    i_valid = 1'b1;
    in_pkt = '{instruction: 32'h0040_006f, pc: 64'h1800, pc_plus4: 64'h1804,
               pc_target_addr_pred: 64'h2000, btb_way: 2'b10,
               branch_pred_taken: 1'b1, log_trace: 1'b1};
    cyc();
    i_valid = 1'b0;
    check("t6_way", 64'(out_pkt.btb_way), 64'd2);
    check("t6_taken", 64'(out_pkt.branch_pred_taken), 64'd1);
    check("t6_target", out_pkt.pc_target_addr_pred, 64'h2000);
    check("t6_trace", 64'(out_pkt.log_trace), 64'd1);
    check("t6_instr", 64'(out_pkt.instruction), 64'h0040_006f);
    i_ready = 1'b1;
    cyc();
    i_ready = 1'b0;
    check("t6_drained", 64'(o_valid), 64'd0);
    cyc();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
